// File: rtl/noc_link_relay_station.sv
// Credit-based relay station for one NoC link: retimes the flit path, buffers flits in a
// local FIFO and tracks downstream credits so the two credit loops are decoupled.
module noc_link_relay_station #(
   parameter int FLIT_WIDTH         = 128,
   parameter int DEST_WIDTH         = 6,
   parameter int NUM_PIPELINE       = 0,
   parameter int LINK_BUFFER_DEPTH  = 4,
   parameter int DOWNSTREAM_CREDITS = 1
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [FLIT_WIDTH-1:0]                        data_in,
   input  logic [DEST_WIDTH-1:0]                        dest_in,
   input  logic                                         is_tail_in,
   input  logic                                         send_in,
   output logic                                         credit_out,
   output logic [FLIT_WIDTH-1:0]                        data_out,
   output logic [DEST_WIDTH-1:0]                        dest_out,
   output logic                                         is_tail_out,
   output logic                                         send_out,
   input  logic                                         credit_in,
   output logic [$clog2(DOWNSTREAM_CREDITS+1)-1:0]      credit_count,
   output logic                                         overflow_err,
   output logic                                         credit_err
);
   localparam int CNT_W     = $clog2(DOWNSTREAM_CREDITS + 1);
   localparam int PTR_W     = (LINK_BUFFER_DEPTH > 1) ? $clog2(LINK_BUFFER_DEPTH) : 1;
   localparam int OCC_W     = $clog2(LINK_BUFFER_DEPTH + 1);
   localparam int FLIT_BITS = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DOWNSTREAM_CREDITS);

   logic                 wr_send;
   logic [FLIT_BITS-1:0] wr_flit;
   logic                 ret_pulse;

   logic                 send_out_reg;
   logic                 credit_out_reg;
   logic [FLIT_BITS-1:0] flit_out_reg;
   logic [CNT_W-1:0]     credit_count_reg;
   logic                 overflow_err_reg;
   logic                 credit_err_reg;

   // The credit return path carries send_out (i.e. the registered pop) through the same
   // number of stages as the flit path, then one final output register.
   generate
      if (NUM_PIPELINE == 0) begin : g_direct
         assign wr_send   = send_in;
         assign wr_flit   = {is_tail_in, dest_in, data_in};
         assign ret_pulse = send_out_reg;
      end else begin : g_pipe
         logic                 send_pipe_reg [NUM_PIPELINE];
         logic [FLIT_BITS-1:0] flit_pipe_reg [NUM_PIPELINE];
         logic                 ret_pipe_reg  [NUM_PIPELINE];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < NUM_PIPELINE; i++) begin
                  send_pipe_reg[i] <= 1'b0;
                  flit_pipe_reg[i] <= '0;
                  ret_pipe_reg[i]  <= 1'b0;
               end
            end else begin
               send_pipe_reg[0] <= send_in;
               flit_pipe_reg[0] <= {is_tail_in, dest_in, data_in};
               ret_pipe_reg[0]  <= send_out_reg;
               for (int i = 1; i < NUM_PIPELINE; i++) begin
                  send_pipe_reg[i] <= send_pipe_reg[i-1];
                  flit_pipe_reg[i] <= flit_pipe_reg[i-1];
                  ret_pipe_reg[i]  <= ret_pipe_reg[i-1];
               end
            end
         end

         assign wr_send   = send_pipe_reg[NUM_PIPELINE-1];
         assign wr_flit   = flit_pipe_reg[NUM_PIPELINE-1];
         assign ret_pulse = ret_pipe_reg[NUM_PIPELINE-1];
      end
   endgenerate

   logic [FLIT_BITS-1:0] fifo_mem [LINK_BUFFER_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [OCC_W-1:0]     occ_reg;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;

   assign fifo_empty = (occ_reg == '0);
   assign fifo_full  = (occ_reg == OCC_W'(LINK_BUFFER_DEPTH));
   assign pop        = !fifo_empty && (credit_count_reg != '0);
   assign push       = wr_send && !fifo_full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(LINK_BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= wr_flit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   // Output flit register doubles as the FIFO's registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         send_out_reg     <= 1'b0;
         flit_out_reg     <= '0;
         credit_out_reg   <= 1'b0;
         credit_count_reg <= CREDIT_MAX;
         overflow_err_reg <= 1'b0;
         credit_err_reg   <= 1'b0;
      end else begin
         send_out_reg   <= pop;
         credit_out_reg <= ret_pulse;
         if (pop) flit_out_reg <= fifo_mem[rd_ptr_reg];
         if (wr_send && fifo_full) overflow_err_reg <= 1'b1;
         case ({pop, credit_in})
            2'b10: credit_count_reg <= credit_count_reg - CNT_W'(1);
            2'b01: begin
               if (credit_count_reg == CREDIT_MAX) credit_err_reg <= 1'b1;
               else credit_count_reg <= credit_count_reg + CNT_W'(1);
            end
            default: credit_count_reg <= credit_count_reg;
         endcase
      end
   end

   assign send_out                           = send_out_reg;
   assign credit_out                         = credit_out_reg;
   assign {is_tail_out, dest_out, data_out}  = flit_out_reg;
   assign credit_count                       = credit_count_reg;
   assign overflow_err                       = overflow_err_reg;
   assign credit_err                         = credit_err_reg;
endmodule

// File: tb/tb_noc_link_relay_station.sv
// Bench for noc_link_relay_station: a P=0 instance driven from a vector table, a P=2
// instance for the pipelined burst, flit payloads checked through scoreboard queues.
module tb_noc_link_relay_station;
   localparam int FW = 128;
   localparam int DW = 6;
   localparam int FB = FW + DW + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          send0 = 0, tail0 = 0, cin0 = 0;
   logic [FW-1:0] data0 = '0;
   logic [DW-1:0] dest0 = '0;
   logic          so0, co0, to0, ovf0, cerr0;
   logic [FW-1:0] do0;
   logic [DW-1:0] de0;
   logic [0:0]    cc0;

   logic          send2 = 0, tail2 = 0, cin2 = 0;
   logic [FW-1:0] data2 = '0;
   logic [DW-1:0] dest2 = '0;
   logic          so2, co2, to2, ovf2, cerr2;
   logic [FW-1:0] do2;
   logic [DW-1:0] de2;
   logic [0:0]    cc2;

   noc_link_relay_station #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0),
      .LINK_BUFFER_DEPTH(4), .DOWNSTREAM_CREDITS(1)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data0), .dest_in(dest0), .is_tail_in(tail0),
      .send_in(send0), .credit_out(co0), .data_out(do0), .dest_out(de0),
      .is_tail_out(to0), .send_out(so0), .credit_in(cin0), .credit_count(cc0),
      .overflow_err(ovf0), .credit_err(cerr0));

   noc_link_relay_station #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(2),
      .LINK_BUFFER_DEPTH(4), .DOWNSTREAM_CREDITS(1)) dut_p2 (
      .clk(clk), .rst_n(rst_n), .data_in(data2), .dest_in(dest2), .is_tail_in(tail2),
      .send_in(send2), .credit_out(co2), .data_out(do2), .dest_out(de2),
      .is_tail_out(to2), .send_out(so2), .credit_in(cin2), .credit_count(cc2),
      .overflow_err(ovf2), .credit_err(cerr2));

   typedef struct packed {
      logic send, tail, acc, cin;
      logic e_send, e_cr, e_cnt, e_ovf, e_cerr;
   } vec_t;

   vec_t          tbl[$];
   logic [FB-1:0] q0[$];
   logic [FB-1:0] q2[$];
   logic [FB-1:0] last0 = '0;
   int            vectors = 0;
   int            miscompares = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic obs0(input string tag);
      if (so0) begin
         if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_unexpected: got flit %0h, required no flit", tag, {to0, de0, do0});
         end else begin
            chk({tag, "_flit"}, {to0, de0, do0}, q0.pop_front());
         end
         last0 = {to0, de0, do0};
      end else begin
         chk({tag, "_hold"}, {to0, de0, do0}, last0);
      end
   endtask

   task automatic drive0(input logic s, input logic t, input logic c, input int n);
      send0 = s; tail0 = t; cin0 = c;
      data0 = {4{32'hC0DE_0000 | 32'(n)}};
      dest0 = DW'(n * 5 + 1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // single flit, credit returned two cycles after send_out
      tbl.push_back(vec_t'(9'b1110_00100));
      tbl.push_back(vec_t'(9'b0000_10000));
      tbl.push_back(vec_t'(9'b0000_01000));
      tbl.push_back(vec_t'(9'b0001_00100));
      tbl.push_back(vec_t'(9'b0000_00100));
      // four flits into a stalled downstream, then one credit per flit
      tbl.push_back(vec_t'(9'b1010_00100));
      tbl.push_back(vec_t'(9'b1010_10000));
      tbl.push_back(vec_t'(9'b1010_01000));
      tbl.push_back(vec_t'(9'b1110_00000));
      tbl.push_back(vec_t'(9'b0000_00000));
      for (int k = 0; k < 3; k++) begin
         tbl.push_back(vec_t'(9'b0001_00100));
         tbl.push_back(vec_t'(9'b0000_10000));
         tbl.push_back(vec_t'(9'b0000_01000));
      end
      // fill the FIFO at zero credits, fifth flit must be dropped
      for (int k = 0; k < 3; k++) tbl.push_back(vec_t'(9'b1010_00000));
      tbl.push_back(vec_t'(9'b1110_00000));
      tbl.push_back(vec_t'(9'b1100_00010));
      tbl.push_back(vec_t'(9'b0000_00010));
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(vec_t'(9'b0001_00110));
         tbl.push_back(vec_t'(9'b0000_10010));
         tbl.push_back(vec_t'(9'b0000_01010));
      end
      // credit returned while already at maximum
      tbl.push_back(vec_t'(9'b0001_00110));
      tbl.push_back(vec_t'(9'b0001_00111));
      tbl.push_back(vec_t'(9'b0000_00111));

      #12;
      chk("rst_send_out", so0, 0);
      chk("rst_credit_out", co0, 0);
      chk("rst_flit", {to0, de0, do0}, 0);
      chk("rst_count", cc0, 1);
      chk("rst_errs", {ovf0, cerr0}, 0);
      chk("rst_p2_state", {so2, co2, cc2, ovf2, cerr2}, 5'b00100);
      tick();
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive0(tbl[i].send, tbl[i].tail, tbl[i].cin, i);
         if (tbl[i].send && tbl[i].acc) q0.push_back({tail0, dest0, data0});
         tick();
         chk($sformatf("v%0d_send_out", i), so0, tbl[i].e_send);
         chk($sformatf("v%0d_credit_out", i), co0, tbl[i].e_cr);
         chk($sformatf("v%0d_count", i), cc0, tbl[i].e_cnt);
         chk($sformatf("v%0d_overflow", i), ovf0, tbl[i].e_ovf);
         chk($sformatf("v%0d_credit_err", i), cerr0, tbl[i].e_cerr);
         obs0($sformatf("v%0d", i));
      end

      // reset asserted mid-burst, away from the clock edge
      drive0(1, 0, 0, 100);
      q0.push_back({tail0, dest0, data0});
      tick();
      obs0("mid_e0");
      drive0(1, 1, 0, 101);
      q0.push_back({tail0, dest0, data0});
      tick();
      chk("mid_send_out", so0, 1);
      obs0("mid_e1");
      drive0(0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_send_out", so0, 0);
      chk("arst_flit", {to0, de0, do0}, 0);
      chk("arst_count", cc0, 1);
      chk("arst_errs", {ovf0, cerr0, co0}, 0);
      q0.delete();
      last0 = '0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("post_rst%0d_send_out", k), so0, 0);
         chk($sformatf("post_rst%0d_credit_out", k), co0, 0);
         chk($sformatf("post_rst%0d_count", k), cc0, 1);
      end
      drive0(1, 1, 0, 200);
      q0.push_back({tail0, dest0, data0});
      tick();
      chk("post_rst_f0_wait", so0, 0);
      drive0(0, 0, 0, 0);
      tick();
      chk("post_rst_f0_send_out", so0, 1);
      obs0("post_rst_f0");

      // P=2 burst with credit_in held high
      for (int k = 0; k < 12; k++) begin
         send2 = (k < 4);
         tail2 = (k == 3);
         cin2  = 1'b1;
         data2 = {4{32'hBEEF_0000 | 32'(k)}};
         dest2 = DW'(k + 40);
         if (send2) q2.push_back({tail2, dest2, data2});
         tick();
         chk($sformatf("p2_%0d_send_out", k), so2, (k >= 3 && k <= 6));
         chk($sformatf("p2_%0d_credit_out", k), co2, (k >= 6 && k <= 9));
         chk($sformatf("p2_%0d_count", k), cc2, 1);
         if (so2) begin
            if (q2.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL p2_%0d_unexpected: got flit %0h, required no flit", k, {to2, de2, do2});
            end else begin
               chk($sformatf("p2_%0d_flit", k), {to2, de2, do2}, q2.pop_front());
            end
         end
      end
      send2 = 1'b0;
      cin2  = 1'b0;
      chk("p2_credit_err", cerr2, 1);
      chk("p2_overflow", ovf2, 0);
      chk("q0_drained", q0.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
